psum_mem_arbiter: RTL
=====================

PSUM_MEM_ARBITER -- requirements
Module: psum_mem_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH 32, psum word width; ADDR_WIDTH 32, memory address width; REG_WIDTH 32, config width; MEM_DELAY 1, memory read latency in cycles (legal range 1..2); FIFO_DEPTH 4, drain skid FIFO depth (at least MEM_DELAY+2).
REQ-002 Clock and reset ports SHALL be: clk in 1, single clock; rst in 1, synchronous, active-low reset.
REQ-003 Accumulator ports SHALL be: acc_radd in ADDR_WIDTH, acc_rden in 1, acc_wadd in ADDR_WIDTH, acc_wren in 1, acc_idat in DATA_WIDTH, acc_odat out DATA_WIDTH, acc_ovld out 1, acc_done in 1 (accumulation complete level).
REQ-004 Drain control ports SHALL be: i_drain_start in 1 (pulse), i_drain_base in ADDR_WIDTH, i_drain_len in REG_WIDTH (words), o_drain_busy out 1, o_drain_done out 1 (one-cycle pulse), o_err out 2 ([0] port conflict, [1] start rejected).
REQ-005 Drain stream ports SHALL be: drn_odat out DATA_WIDTH, drn_ovld out 1, drn_ordy in 1.
REQ-006 Memory controller ports SHALL be: mem_radd out ADDR_WIDTH, mem_rden out 1, mem_wadd out ADDR_WIDTH, mem_wren out 1, mem_idat out DATA_WIDTH, mem_odat in DATA_WIDTH, mem_ovld in 1.

Function
REQ-007 Write path SHALL be combinational pass-through: mem_wadd=acc_wadd, mem_wren=acc_wren, mem_idat=acc_idat, in every state; the drain never writes.
REQ-008 mem_rden SHALL be acc_rden OR drain_issue; mem_radd SHALL be acc_radd when acc_rden=1, else the drain address.
REQ-009 Accumulator reads SHALL have absolute priority and never stall; a drain read coinciding with acc_rden SHALL be suppressed and retried next cycle with the same address.
REQ-010 Each issued read SHALL push a tag (NONE/ACC/DRN) into a MEM_DELAY-stage shift register; a NONE tag SHALL be pushed on cycles with no read.
REQ-011 On mem_ovld, the tag at stage MEM_DELAY-1 SHALL route the data: ACC -> acc_ovld=1, acc_odat=mem_odat same cycle; DRN -> write into the drain FIFO; NONE -> data discarded.
REQ-012 FSM states SHALL be IDLE, DRAIN, FLUSH, DONE; o_drain_busy=1 in DRAIN and FLUSH.
REQ-013 IDLE->DRAIN on i_drain_start when acc_done=1 and i_drain_len>0; the drain address SHALL load i_drain_base and the remaining count SHALL load i_drain_len.
REQ-014 i_drain_start in IDLE with acc_done=1 and i_drain_len=0 SHALL go IDLE->DONE directly, no reads issued.
REQ-015 i_drain_start with acc_done=0, or in any state other than IDLE, SHALL be ignored and set o_err[1].
REQ-016 In DRAIN, drain_issue SHALL assert when remaining>0, acc_rden=0 and (FIFO count + DRN tags in flight) < FIFO_DEPTH; each issue increments the address by 1 (wrapping modulo 2^ADDR_WIDTH) and decrements remaining.
REQ-017 DRAIN->FLUSH in the cycle after remaining reaches 0; FLUSH->DONE when no DRN tag is in flight and the FIFO is empty; DONE->IDLE after one cycle with o_drain_done=1 for that cycle only.
REQ-018 drn_ovld SHALL equal FIFO not-empty; a word SHALL pop when drn_ovld and drn_ordy are both 1; drn_odat SHALL be the FIFO head; FIFO write and pop in the same cycle SHALL leave the count unchanged.
REQ-019 The FIFO SHALL never overflow; a DRN write into a full FIFO SHALL be impossible by REQ-016.
REQ-020 acc_rden or acc_wren while in DRAIN or FLUSH SHALL set o_err[0]; the accumulator access SHALL still be served.
REQ-021 Minimum drain read-to-drn_ovld latency SHALL be MEM_DELAY+1 cycles from issue.

Reset
REQ-022 While rst=0 at a clock edge: FSM->IDLE, tags->NONE, FIFO empty, address/remaining cleared, o_err=0; outputs SHALL be acc_ovld=0, drn_ovld=0, mem_rden=0 when acc_rden=0, o_drain_busy=0, o_drain_done=0.
REQ-023 Reset mid-drain SHALL abort without o_drain_done; read data returning after reset SHALL be discarded (NONE tags).
REQ-024 o_err bits SHALL be sticky, cleared only by reset.

Verification
REQ-025 acc_done=1, start base=0x100 len=8, drn_ordy=1 -> mem_radd 0x100..0x107 on 8 consecutive cycles, 8 drn words in order, one o_drain_done pulse.
REQ-026 Same drain with drn_ordy=0 -> exactly FIFO_DEPTH reads issued then stall; releasing drn_ordy resumes, no word lost or duplicated.
REQ-027 acc_rden=1 on the third drain-issue cycle -> mem_radd=acc_radd, its data returns on acc_ovld only, drain address 0x102 retried next cycle, o_err[0]=1.
REQ-028 Start with acc_done=0 -> no read, o_err[1]=1, state IDLE; start with len=0 -> o_drain_done pulse one cycle later, no reads.
REQ-029 rst=0 asserted after 3 of 8 drain reads -> next cycle busy=0, drn_ovld=0; late mem_ovld dropped; no o_drain_done.
REQ-030 Run all scenarios with MEM_DELAY=1 and MEM_DELAY=2.

Source files
------------

// File: rtl/psum_mem_arbiter.sv
// Shares one memory controller between the accumulator and a burst drain of
// partial sums. Accumulator reads always win; drain reads fill a small skid FIFO.
module psum_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32,
  parameter int MEM_DELAY  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] acc_radd,
  input  logic                  acc_rden,
  input  logic [ADDR_WIDTH-1:0] acc_wadd,
  input  logic                  acc_wren,
  input  logic [DATA_WIDTH-1:0] acc_idat,
  output logic [DATA_WIDTH-1:0] acc_odat,
  output logic                  acc_ovld,
  input  logic                  acc_done,
  input  logic                  i_drain_start,
  input  logic [ADDR_WIDTH-1:0] i_drain_base,
  input  logic [REG_WIDTH-1:0]  i_drain_len,
  output logic                  o_drain_busy,
  output logic                  o_drain_done,
  output logic [1:0]            o_err,
  output logic [DATA_WIDTH-1:0] drn_odat,
  output logic                  drn_ovld,
  input  logic                  drn_ordy,
  output logic [ADDR_WIDTH-1:0] mem_radd,
  output logic                  mem_rden,
  output logic [ADDR_WIDTH-1:0] mem_wadd,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_idat,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  input  logic                  mem_ovld
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + MEM_DELAY + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_FLUSH, ST_DONE} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_ACC, TAG_DRN} tag_t;

  state_t                state_q, state_d;
  tag_t                  tag_q [MEM_DELAY];
  tag_t                  tag_d [MEM_DELAY];
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_WIDTH-1:0]  remain_q, remain_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            err_q, err_d;
  logic [OCC_W-1:0]      inflight, occupancy;
  logic                  drain_issue, fifo_wr, fifo_pop;
  tag_t                  tag_out;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Write path is a straight pass-through; read port muxing gives the accumulator priority.
  assign mem_wadd     = acc_wadd;
  assign mem_wren     = acc_wren;
  assign mem_idat     = acc_idat;
  assign mem_rden     = acc_rden | drain_issue;
  assign mem_radd     = acc_rden ? acc_radd : addr_q;
  assign tag_out      = tag_q[MEM_DELAY-1];
  assign acc_odat     = mem_odat;
  assign acc_ovld     = rst & mem_ovld & (tag_out == TAG_ACC);
  assign fifo_wr      = mem_ovld & (tag_out == TAG_DRN);
  assign drn_ovld     = rst & (cnt_q != '0);
  assign drn_odat     = fifo_mem_q[rd_ptr_q];
  assign fifo_pop     = drn_ovld & drn_ordy;
  assign o_drain_busy = rst & ((state_q == ST_DRAIN) || (state_q == ST_FLUSH));
  assign o_drain_done = rst & (state_q == ST_DONE);
  assign o_err        = err_q;

  // Count drain reads still in the memory pipe so the FIFO can never be oversubscribed.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_DELAY; i++) begin
      inflight = inflight + OCC_W'(tag_q[i] == TAG_DRN);
    end
    occupancy = OCC_W'(cnt_q) + inflight;
  end

  // Drain FSM next state, address/length bookkeeping and sticky error flags.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    err_d       = err_q;
    drain_issue = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_drain_start && acc_done) begin
          if (i_drain_len != '0) begin
            state_d  = ST_DRAIN;
            addr_d   = i_drain_base;
            remain_d = i_drain_len;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        if (remain_q == '0) begin
          state_d = ST_FLUSH;
        end else if (rst && !acc_rden && (occupancy < OCC_W'(FIFO_DEPTH))) begin
          drain_issue = 1'b1;
          addr_d      = addr_q + ADDR_WIDTH'(1);
          remain_d    = remain_q - REG_WIDTH'(1);
        end
      end
      ST_FLUSH: begin
        if ((inflight == '0) && (cnt_q == '0)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (i_drain_start && !((state_q == ST_IDLE) && acc_done)) begin
      err_d[1] = 1'b1;
    end
    if ((acc_rden || acc_wren) && ((state_q == ST_DRAIN) || (state_q == ST_FLUSH))) begin
      err_d[0] = 1'b1;
    end
  end

  // Tag pipeline tracks who owns each outstanding read; the skid FIFO buffers drain data.
  always_comb begin
    tag_d[0] = acc_rden ? TAG_ACC : (drain_issue ? TAG_DRN : TAG_NONE);
    for (int i = 1; i < MEM_DELAY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    if (fifo_wr) begin
      fifo_mem_d[wr_ptr_q] = mem_odat;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (fifo_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (fifo_wr && !fifo_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!fifo_wr && fifo_pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      for (int i = 0; i < MEM_DELAY; i++) begin
        tag_q[i] <= TAG_NONE;
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      for (int i = 0; i < MEM_DELAY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // FIFO storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

endmodule
